// File: rtl/alarm_sched.sv
// Multi-channel alarm scheduler: per-channel compare/period/enable registers matched
// against the system microsecond stamp, with a pending mask, interrupt and a round-robin claim port.
module alarm_sched #(
  parameter int unsigned NR_CH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] stamp,
  input  logic            stamp_tick,
  output logic            intr,
  input  logic            bus_req,
  input  logic            bus_wen,
  input  logic [XLEN-1:0] bus_addr,
  input  logic [XLEN-1:0] bus_dat_i,
  output logic [XLEN-1:0] bus_dat_o,
  output logic            bus_ready
);

  logic [XLEN-1:0] r_cmp    [4];
  logic [XLEN-1:0] r_period [4];
  logic [3:0]      r_en;
  logic [3:0]      r_pending;
  logic [1:0]      r_rr_ptr;
  logic [XLEN-1:0] r_dat_o;

  logic [3:0]      w_idx;
  logic            w_rd;
  logic            w_wr;
  logic [3:0]      w_fire;
  logic [XLEN-1:0] w_diff;
  logic            w_found;
  logic [1:0]      w_cand;
  logic [1:0]      w_claim_id;
  logic            w_claim;
  logic [XLEN-1:0] w_claim_word;
  logic [XLEN-1:0] w_rd_data;
  logic [3:0]      w_clr;
  logic [3:0]      w_pend_nxt;
  logic            w_unused;

  assign w_idx     = bus_addr[5:2];
  assign w_rd      = bus_req & ~bus_wen;
  assign w_wr      = bus_req & bus_wen;
  assign w_unused  = ^{bus_addr[XLEN-1:6], bus_addr[1:0]};
  assign bus_ready = 1'b1;
  assign bus_dat_o = r_dat_o;
  assign intr      = |r_pending;

  // Storage is always four channels wide; channels >= NR_CH are never written and stay 0.
  // Wrap-safe compare: sign bit of (stamp - CMP). A same-cycle write clearing EN suppresses the fire.
  always_comb begin
    w_fire = '0;
    w_diff = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      w_diff    = stamp - r_cmp[n];
      w_fire[n] = stamp_tick && r_en[n] && !w_diff[XLEN-1] &&
                  !(w_wr && (w_idx == 4'(8 + n)) && !bus_dat_i[0]);
    end
  end

  // Round-robin search starting one past the last claimed channel.
  always_comb begin
    w_found    = 1'b0;
    w_claim_id = '0;
    w_cand     = '0;
    for (int unsigned k = 1; k <= NR_CH; k++) begin
      w_cand = 2'((32'(r_rr_ptr) + k) % NR_CH);
      if (!w_found && r_pending[w_cand]) begin
        w_found    = 1'b1;
        w_claim_id = w_cand;
      end
    end
  end

  assign w_claim = w_rd && (w_idx == 4'd13) && w_found;

  always_comb begin
    w_claim_word        = '0;
    w_claim_word[31]    = 1'b1;
    w_claim_word[1:0]   = w_claim_id;
    w_rd_data           = '0;
    case (w_idx)
      4'd0, 4'd1, 4'd2, 4'd3:   w_rd_data = r_cmp[w_idx[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7:   w_rd_data = r_period[w_idx[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: w_rd_data = XLEN'(r_en[w_idx[1:0]]);
      4'd12:                    w_rd_data = XLEN'(r_pending);
      4'd13:                    w_rd_data = w_found ? w_claim_word : '0;
      default:                  w_rd_data = '0;
    endcase
  end

  // Fire is OR-ed in after clears so a coincident W1C or claim cannot drop a new event.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_idx == 4'd12)) w_clr = bus_dat_i[3:0];
    if (w_claim) w_clr[w_claim_id] = 1'b1;
    w_pend_nxt = (r_pending & ~w_clr) | w_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_cmp[n]    <= '0;
        r_period[n] <= '0;
      end
      r_en      <= '0;
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_dat_o   <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (n < NR_CH) begin
          if (w_wr && (w_idx == 4'(n)))
            r_cmp[n] <= bus_dat_i;
          else if (w_fire[n] && (r_period[n] != '0))
            r_cmp[n] <= r_cmp[n] + r_period[n];
          if (w_wr && (w_idx == 4'(4 + n)))
            r_period[n] <= bus_dat_i;
          if (w_wr && (w_idx == 4'(8 + n)))
            r_en[n] <= bus_dat_i[0];
          else if (w_fire[n] && (r_period[n] == '0))
            r_en[n] <= 1'b0;
        end
      end
      r_pending <= w_pend_nxt;
      if (w_claim) r_rr_ptr <= w_claim_id;
      r_dat_o <= w_rd ? w_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_alarm_sched.sv
// Directed scoreboard bench for alarm_sched: reads push expected {data, intr} entries,
// a negedge monitor pops them when the registered read data appears.
module tb_alarm_sched;

  localparam logic [31:0] A_CMP0 = 32'd0,  A_CMP1 = 32'd4,  A_CMP2 = 32'd8,  A_CMP3 = 32'd12;
  localparam logic [31:0] A_PER0 = 32'd16, A_PER1 = 32'd20, A_PER2 = 32'd24, A_PER3 = 32'd28;
  localparam logic [31:0] A_CTL0 = 32'd32, A_CTL1 = 32'd36, A_CTL2 = 32'd40, A_CTL3 = 32'd44;
  localparam logic [31:0] A_PEND = 32'd48, A_CLAIM = 32'd52;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] stamp = '0;
  logic        stamp_tick = 1'b0;
  logic        intr;
  logic        bus_req = 1'b0;
  logic        bus_wen = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_dat_i = '0;
  logic [31:0] bus_dat_o;
  logic        bus_ready;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        intr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_d     = 1'b0;

  always #5 clk = ~clk;

  alarm_sched #(.NR_CH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .stamp(stamp), .stamp_tick(stamp_tick), .intr(intr),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o), .bus_ready(bus_ready)
  );

  always @(posedge clk) rd_d <= bus_req && !bus_wen && rst;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if (rd_d) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: got data=%h with no expected entry", bus_dat_o);
        end else begin
          e = sb.pop_front();
          if (bus_dat_o !== e.data || intr !== e.intr) begin
            n_fail++;
            $display("FAIL %s: got data=%h intr=%b, expected data=%h intr=%b",
                     e.name, bus_dat_o, intr, e.data, e.intr);
          end
        end
      end else if (bus_dat_o !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_zero: got data=%h, expected 00000000", bus_dat_o);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no finish, expected end within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic cycle(input logic req, input logic wen, input logic [31:0] addr,
                       input logic [31:0] dat, input logic tk, input logic [31:0] st);
    bus_req = req; bus_wen = wen; bus_addr = addr; bus_dat_i = dat;
    stamp = st; stamp_tick = tk;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_wen = 1'b0; stamp_tick = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] d, input logic i);
    exp_t e;
    e.name = name; e.data = d; e.intr = i;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, stamp);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] d, input logic i);
    expect_rd(name, d, i);
    cycle(1'b1, 1'b0, a, '0, 1'b0, stamp);
  endtask

  task automatic tick(input logic [31:0] st);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, st);
  endtask

  initial begin : stim
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // reset state
    rd("rst_cmp0",  A_CMP0,  32'h0, 1'b0);
    rd("rst_pend",  A_PEND,  32'h0, 1'b0);
    rd("rst_ctl0",  A_CTL0,  32'h0, 1'b0);
    rd("rst_claim", A_CLAIM, 32'h0, 1'b0);

    // one-shot
    wr(A_CMP0, 32'd100); wr(A_PER0, 32'd0); wr(A_CTL0, 32'd1);
    tick(32'd99);
    rd("os_early_pend", A_PEND, 32'h0, 1'b0);
    tick(32'd100);
    rd("os_fire_pend", A_PEND, 32'h1, 1'b1);
    rd("os_en_clear",  A_CTL0, 32'h0, 1'b1);
    wr(A_PEND, 32'h1);
    rd("os_w1c", A_PEND, 32'h0, 1'b0);
    tick(32'd200);
    rd("os_no_refire", A_PEND, 32'h0, 1'b0);
    rd("os_cmp_kept",  A_CMP0, 32'd100, 1'b0);

    // periodic with wrap
    wr(A_CMP1, 32'hFFFF_FFF0); wr(A_PER1, 32'h20); wr(A_CTL1, 32'd1);
    tick(32'hFFFF_FFF0);
    rd("wrap_cmp",  A_CMP1, 32'h10, 1'b1);
    rd("wrap_pend", A_PEND, 32'h2,  1'b1);
    wr(A_PEND, 32'h2);
    tick(32'h5);
    rd("wrap_nofire", A_PEND, 32'h0, 1'b0);
    tick(32'h10);
    rd("wrap_fire2", A_PEND, 32'h2,  1'b1);
    rd("wrap_cmp2",  A_CMP1, 32'h30, 1'b1);
    wr(A_PEND, 32'h2);
    stamp = 32'h40;
    repeat (3) @(posedge clk); #1;
    rd("no_tick_nofire", A_PEND, 32'h0, 1'b0);
    wr(A_CTL1, 32'd0);

    // round-robin claims
    wr(A_CMP0, 32'h0); wr(A_CTL0, 32'd1);
    wr(A_CMP1, 32'h0); wr(A_PER1, 32'h0); wr(A_CTL1, 32'd1);
    wr(A_CMP3, 32'h0); wr(A_CTL3, 32'd1);
    tick(32'h100);
    rd("rr_pend",   A_PEND,  32'hB,         1'b1);
    rd("rr_claim1", A_CLAIM, 32'h8000_0001, 1'b1);
    rd("rr_claim2", A_CLAIM, 32'h8000_0003, 1'b1);
    rd("rr_claim3", A_CLAIM, 32'h8000_0000, 1'b0);
    rd("rr_claim4", A_CLAIM, 32'h0,         1'b0);
    rd("rr_pend0",  A_PEND,  32'h0,         1'b0);

    // fire vs W1C, fire vs claim
    wr(A_CMP2, 32'h200); wr(A_PER2, 32'h10); wr(A_CTL2, 32'd1);
    tick(32'h200);
    cycle(1'b1, 1'b1, A_PEND, 32'h4, 1'b1, 32'h210);
    rd("col_w1c_pend", A_PEND, 32'h4,   1'b1);
    rd("col_w1c_cmp",  A_CMP2, 32'h220, 1'b1);
    expect_rd("col_claim", 32'h8000_0002, 1'b1);
    cycle(1'b1, 1'b0, A_CLAIM, '0, 1'b1, 32'h220);
    rd("col_claim_pend", A_PEND, 32'h4, 1'b1);
    wr(A_CTL2, 32'd0); wr(A_PEND, 32'h4);
    rd("col_clear", A_PEND, 32'h0, 1'b0);

    // fire vs CMP write
    wr(A_CTL2, 32'd1);
    cycle(1'b1, 1'b1, A_CMP2, 32'h500, 1'b1, 32'h230);
    rd("cmpwr_cmp",  A_CMP2, 32'h500, 1'b1);
    rd("cmpwr_pend", A_PEND, 32'h4,   1'b1);
    wr(A_PEND, 32'h4);

    // EN clear in fire cycle, then EN set in tick cycle
    cycle(1'b1, 1'b1, A_CTL2, 32'h0, 1'b1, 32'h600);
    rd("enclr_pend", A_PEND, 32'h0,   1'b0);
    rd("enclr_cmp",  A_CMP2, 32'h500, 1'b0);
    rd("enclr_ctl",  A_CTL2, 32'h0,   1'b0);
    cycle(1'b1, 1'b1, A_CTL2, 32'h1, 1'b1, 32'h600);
    rd("enset_same_cyc", A_PEND, 32'h0, 1'b0);
    tick(32'h600);
    rd("enset_next", A_PEND, 32'h4,   1'b1);
    rd("enset_cmp",  A_CMP2, 32'h510, 1'b1);
    wr(A_CTL2, 32'd0); wr(A_PEND, 32'h4);

    // zero W1C and CLAIM writes are no-ops
    wr(A_CMP0, 32'h10); wr(A_CTL0, 32'd1);
    tick(32'h700);
    wr(A_PEND, 32'h0);
    wr(A_CLAIM, 32'hFFFF_FFFF);
    rd("noop_writes", A_PEND, 32'h1, 1'b1);

    // late enable
    wr(A_CMP3, 32'd200);
    stamp = 32'd500;
    wr(A_CTL3, 32'd1);
    tick(32'd500);
    rd("late_pend", A_PEND, 32'h9, 1'b1);
    rd("late_ctl",  A_CTL3, 32'h0, 1'b1);

    // unmapped indices
    wr(32'd56, 32'hDEAD_BEEF);
    rd("unmapped14", 32'd56, 32'h0, 1'b1);
    rd("unmapped15", 32'd60, 32'h0, 1'b1);

    // reset mid-operation
    wr(A_CMP1, 32'h0);   wr(A_CTL1, 32'd1);
    wr(A_CMP2, 32'h510); wr(A_CTL2, 32'd1);
    wr(A_CTL0, 32'd1);   wr(A_CTL3, 32'd1);
    tick(32'h1000);
    wr(A_CTL0, 32'd1); wr(A_CTL1, 32'd1); wr(A_CTL3, 32'd1);
    rd("pre_rst_pend", A_PEND, 32'hF, 1'b1);
    rd("pre_rst_ctl0", A_CTL0, 32'h1, 1'b1);
    rst = 1'b0;
    cycle(1'b1, 1'b0, A_PEND, '0, 1'b1, 32'h2000);
    rst = 1'b1;
    rd("post_rst_pend", A_PEND, 32'h0, 1'b0);
    rd("post_rst_cmp0", A_CMP0, 32'h0, 1'b0);
    rd("post_rst_cmp2", A_CMP2, 32'h0, 1'b0);
    rd("post_rst_cmp3", A_CMP3, 32'h0, 1'b0);
    rd("post_rst_per2", A_PER2, 32'h0, 1'b0);
    rd("post_rst_ctl0", A_CTL0, 32'h0, 1'b0);
    rd("post_rst_ctl1", A_CTL1, 32'h0, 1'b0);
    rd("post_rst_ctl2", A_CTL2, 32'h0, 1'b0);
    rd("post_rst_ctl3", A_CTL3, 32'h0, 1'b0);
    tick(32'h3000);
    rd("post_rst_nofire", A_PEND, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_sched.md
ALARM_SCHED -- requirements
Module: alarm_sched

Interface
REQ-001 Parameter NR_CH, default 4, number of alarm channels; legal range 1..4.
REQ-002 Parameter XLEN, default 32, data and stamp width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 stamp  input  XLEN  free-running microsecond count from the system timer.
REQ-006 stamp_tick  input  1  one-cycle pulse, high in the first cycle `stamp` holds a new value.
REQ-007 intr  output  1  alarm interrupt request to the CPU.
REQ-008 bus_req  input  1  bus slave select.
REQ-009 bus_wen  input  1  write enable; full-word writes only.
REQ-010 bus_addr  input  XLEN  byte address; only bits [5:2] are decoded.
REQ-011 bus_dat_i  input  XLEN  write data.
REQ-012 bus_dat_o  output  XLEN  registered read data.
REQ-013 bus_ready  output  1  tied to 1.

Function
REQ-014 Register index = bus_addr[5:2]: 0-3 CMPn; 4-7 PERIODn; 8-11 CTRLn (bit0 = EN); 12 PENDING (bits [NR_CH-1:0], write-1-to-clear); 13 CLAIM (read-only); all other indices read 0 and ignore writes.
REQ-015 Registers for channels n >= NR_CH shall read 0 and ignore writes.
REQ-016 Read data shall be registered: bus_dat_o in cycle T+1 = value selected by a read at T; bus_dat_o = 0 in any cycle after one with bus_req low.
REQ-017 Channel n fires at a cycle with stamp_tick=1, EN=1, and (stamp - CMPn) interpreted as a signed XLEN value >= 0 (wrap-safe compare).
REQ-018 On fire: PENDING[n] <= 1; if PERIODn != 0, CMPn <= CMPn + PERIODn (modulo 2^XLEN); if PERIODn == 0, EN <= 0 (one-shot).
REQ-019 No fire shall occur in cycles with stamp_tick=0.
REQ-020 intr = OR of PENDING bits, driven from the register; asserts the cycle after the firing tick.
REQ-021 CLAIM read: round-robin arbiter picks the first set PENDING bit searching from rr_ptr+1 upward modulo NR_CH; returns {bit31 = 1, bits[1:0] = id}, clears PENDING[id], and sets rr_ptr <= id.
REQ-022 CLAIM read with PENDING == 0 returns 0 and changes no state.
REQ-023 Simultaneous fire on n and PENDING W1C or CLAIM clear of n: fire wins, PENDING[n] stays 1.
REQ-024 Simultaneous fire on n and bus write to CMPn: bus value is loaded, periodic reload is dropped, PENDING[n] is still set.
REQ-025 Bus write clearing EN in a fire cycle of n: write wins, no fire, PENDING[n] unchanged.
REQ-026 Bus write setting EN takes effect for compares from the next cycle.
REQ-027 Writes to PENDING with 0 bits and to CLAIM shall have no effect.

Reset
REQ-028 While rst=0 at a clock edge: CMPn, PERIODn, CTRLn, PENDING, rr_ptr, bus_dat_o <= 0; intr = 0 from the following cycle.
REQ-029 Reset mid-operation shall discard pending interrupts and in-flight reads; no fire on the reset cycle.

Verification
REQ-030 One-shot: CMP0=100, PERIOD0=0, EN0=1; tick with stamp=99 -> no fire; tick with stamp=100 -> PENDING=0x1, intr=1 next cycle, EN0 reads 0.
REQ-031 Periodic wrap: CMP1=0xFFFFFFF0, PERIOD1=0x20; tick at stamp=0xFFFFFFF0 -> fire, CMP1 reads 0x00000010; tick at stamp=0x5 -> no fire; tick at stamp=0x10 -> fire.
REQ-032 Round-robin: PENDING=0xB, rr_ptr=0; successive CLAIM reads -> 0x80000001, 0x80000003, 0x80000000, then 0x00000000; intr drops after third claim.
REQ-033 Collision: fire on ch2 in same cycle as W1C write 0x4 to PENDING -> PENDING[2] reads 1, intr stays 1.
REQ-034 Late enable: stamp=500, write CMP3=200, EN3=1 -> fires on the next tick (past deadline), one-shot clears EN3.
REQ-035 Reset: rst=0 for one cycle with PENDING=0xF, EN all 1 -> all registers read 0, intr=0, no fire on following ticks.
